uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, i_clk cycles per bit (115200 baud at 100 MHz); legal values >= 4.
REQ-002 SHALL have port i_clk  input  1  system clock, 100 MHz.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_serialRX  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port o_data  output  8  last correctly received byte.
REQ-006 SHALL have port o_valid  output  1  one-cycle pulse: o_data updated.
REQ-007 SHALL have port o_busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-008 SHALL have port o_frameErr  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port o_parityErr  output  1  one-cycle pulse: parity mismatch; constant 0 without UART_RX_PARITY_EN.

Function
REQ-010 SHALL pass i_serialRX through a 2-flop synchronizer, reset to 1; all logic uses the synchronized value.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-012 IDLE: a synchronized low SHALL load the bit counter and enter START.
REQ-013 START: after CLKS_PER_BIT/2 cycles, line low -> DATA; line high -> IDLE (glitch rejected, no output pulses).
REQ-014 DATA: SHALL sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register; the 3-bit index SHALL not wrap past 7.
REQ-015 After the 8th bit SHALL go to PARITY if the macro is defined, else STOP.
REQ-016 STOP: sampled 1 -> o_data loaded, o_valid high for exactly 1 cycle, next state IDLE (back-to-back frames accepted).
REQ-017 STOP: sampled 0 -> o_frameErr pulse, o_data unchanged, no o_valid, next state BREAK.
REQ-018 BREAK: SHALL remain until the line is sampled high, then IDLE.
REQ-019 o_valid and o_frameErr SHALL never assert in the same cycle.
REQ-020 Bit-period counter width SHALL be $clog2(CLKS_PER_BIT); it reloads on every sample.

Reset
REQ-021 i_rst SHALL asynchronously force state IDLE, o_data=8'h00, o_valid=0, o_busy=0, o_frameErr=0, o_parityErr=0, synchronizer flops=1.
REQ-022 Reset mid-frame SHALL discard the partial byte; after release, the remaining bits of that frame SHALL NOT produce o_valid unless a fresh falling edge is detected.

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: one even-parity bit follows bit 7 and is sampled in PARITY.
REQ-024 With the macro: on mismatch, SHALL pulse o_parityErr in the STOP sample cycle and suppress o_valid; o_data unchanged.
REQ-025 Without the macro: PARITY state unreachable, o_parityErr tied 0, frame is 8N1.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum, DATA_BITS=8 and the default CLKS_PER_BIT.
REQ-027 The synchronizer SHALL be sub-module uart_rx_sync (2-flop, parameterized reset value).

Verification (CLKS_PER_BIT=16)
REQ-028 Send 8N1 frame 0xA5 -> o_data=0xA5, one o_valid pulse at mid-stop + 1 cycle, no error pulses.
REQ-029 Hold line low 4 cycles then high -> state returns to IDLE, no pulses, o_busy low within 10 cycles.
REQ-030 Send 0x3C with stop bit 0, hold line low 40 cycles -> o_frameErr pulse, o_data keeps previous 0xA5, o_busy high until line is high.
REQ-031 Send back-to-back frames 0x00, 0xFF with no idle gap -> two o_valid pulses, o_data 0x00 then 0xFF.
REQ-032 Assert i_rst during bit 4 of 0x5A -> all outputs reset; no o_valid for that frame.
REQ-033 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> o_parityErr pulse, no o_valid; with parity bit 1 -> o_valid, o_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;
    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// Bundle of the receiver's serial input and byte-side outputs.
interface uart_rx_if;
    logic       serial_rx;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    modport master (
        input  serial_rx,
        output data, valid, busy, frame_err, parity_err
    );

    modport slave (
        output serial_rx,
        input  data, valid, busy, frame_err, parity_err
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer with a configurable reset value.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {2{RST_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with parity checking.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_serialRX,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_frameErr,
    output logic       o_parityErr
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic            w_rx;
    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_busy;
    logic            r_frame_err;
    logic            r_parity_err;
    logic            r_par_bad;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_serialRX),
        .o_q   (w_rx)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_par_bad    <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx) begin
                        r_cnt     <= '0;
                        r_idx     <= '0;
                        r_par_bad <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= START;
                    end
                end
                // Re-check the start bit at its centre so short glitches are dropped.
                START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rx) begin
                            r_state <= DATA;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt     <= '0;
                        r_par_bad <= (^r_shift) ^ w_rx;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                            if (r_par_bad) begin
                                r_parity_err <= 1'b1;
                            end else begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                BREAK: begin
                    if (w_rx) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_busy      = r_busy;
    assign o_frameErr  = r_frame_err;
    // Without parity support r_par_bad never sets, so this output stays 0.
    assign o_parityErr = r_parity_err;
endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx at 16 clocks per bit.
module tb_uart_rx;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    uart_rx_if u_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_serialRX  (u_if.serial_rx),
        .o_data      (u_if.data),
        .o_valid     (u_if.valid),
        .o_busy      (u_if.busy),
        .o_frameErr  (u_if.frame_err),
        .o_parityErr (u_if.parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Output monitor, sampled on the falling edge.
    int v_cycles = 0, v_pulses = 0, fe_cnt = 0, pe_cnt = 0, both_cnt = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (u_if.valid === 1'b1) begin
            v_cycles++;
            if (prev_v !== 1'b1) v_pulses++;
        end
        if (u_if.frame_err === 1'b1) fe_cnt++;
        if (u_if.parity_err === 1'b1) pe_cnt++;
        if (u_if.valid === 1'b1 && u_if.frame_err === 1'b1) both_cnt++;
        prev_v = u_if.valid;
    end

    int s_vc, s_vp, s_fe, s_pe;
    logic [7:0] exp_data;

    task automatic snap();
        s_vc = v_cycles; s_vp = v_pulses; s_fe = fe_cnt; s_pe = pe_cnt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic drive_bit(input logic b, input int n);
        u_if.serial_rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
        if (PAR_EN) drive_bit(par_b, CPB);
        drive_bit(stop_b, CPB);
    endtask

    // Reference outcome of one frame, straight from the frame format rules.
    task automatic check_frame(input string tag, input logic [7:0] d, input logic stop_b,
                               input logic par_b);
        bit ferr, perr, good;
        ferr = !stop_b;
        perr = stop_b && PAR_EN && ((^d) ^ par_b);
        good = stop_b && !perr;
        if (good) exp_data = d;
        chk({tag, "_valid"},  v_pulses - s_vp, good ? 1 : 0);
        chk({tag, "_vwidth"}, v_cycles - s_vc, good ? 1 : 0);
        chk({tag, "_ferr"},   fe_cnt - s_fe, ferr ? 1 : 0);
        chk({tag, "_perr"},   pe_cnt - s_pe, perr ? 1 : 0);
        chk({tag, "_data"},   u_if.data, exp_data);
        $display("frame %s data=%02h stop=%0b par=%0b -> o_data=%02h", tag, d, stop_b, par_b,
                 u_if.data);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (u_if.busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_busy_low"}, u_if.busy, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic stop_b, par_b;
        u_if.serial_rx = 1'b1;
        exp_data = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", u_if.data, 8'h00);
        chk("rst_valid", u_if.valid, 1'b0);
        chk("rst_busy", u_if.busy, 1'b0);
        chk("rst_ferr", u_if.frame_err, 1'b0);
        chk("rst_perr", u_if.parity_err, 1'b0);
        rst = 1'b0;
        drive_bit(1'b1, 4 * CPB);

        // Basic frame.
        snap();
        send_frame(8'hA5, 1'b1, ^8'hA5);
        check_frame("a5", 8'hA5, 1'b1, ^8'hA5);
        drive_bit(1'b1, 2 * CPB);

        // Start-bit glitch.
        snap();
        drive_bit(1'b0, 4);
        chk("glitch_busy_high", u_if.busy, 1'b1);
        drive_bit(1'b1, 1);
        wait_idle("glitch", 10);
        drive_bit(1'b1, CPB);
        chk("glitch_pulses", (v_pulses - s_vp) + (fe_cnt - s_fe) + (pe_cnt - s_pe), 0);

        // Framing error followed by a held-low line.
        snap();
        send_frame(8'h3C, 1'b0, ^8'h3C);
        drive_bit(1'b0, 40);
        check_frame("3c_ferr", 8'h3C, 1'b0, ^8'h3C);
        chk("break_busy", u_if.busy, 1'b1);
        drive_bit(1'b1, 1);
        wait_idle("break", 10);
        drive_bit(1'b1, 2 * CPB);

        // Back-to-back frames, no idle gap.
        snap();
        send_frame(8'h00, 1'b1, 1'b0);
        check_frame("b2b_00", 8'h00, 1'b1, 1'b0);
        snap();
        send_frame(8'hFF, 1'b1, 1'b0);
        check_frame("b2b_ff", 8'hFF, 1'b1, 1'b0);
        drive_bit(1'b1, 2 * CPB);

        // Reset during bit 4 of 0x5A, held until the stop bit.
        snap();
        d = 8'h5A;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(d[i], CPB);
        drive_bit(d[4], CPB / 2);
        rst = 1'b1;
        #1;
        exp_data = 8'h00;
        chk("midrst_data", u_if.data, 8'h00);
        chk("midrst_busy", u_if.busy, 1'b0);
        chk("midrst_valid", u_if.valid, 1'b0);
        drive_bit(d[4], CPB / 2);
        for (int i = 5; i < 8; i++) drive_bit(d[i], CPB);
        drive_bit(1'b1, 4);
        rst = 1'b0;
        drive_bit(1'b1, 3 * CPB);
        chk("midrst_novalid", v_pulses - s_vp, 0);
        chk("midrst_data_after", u_if.data, 8'h00);
        chk("midrst_idle", u_if.busy, 1'b0);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        check_frame("par_bad", 8'h07, 1'b1, 1'b0);
        drive_bit(1'b1, CPB);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        check_frame("par_good", 8'h07, 1'b1, 1'b1);
        drive_bit(1'b1, CPB);
`endif

        // Randomized frames, occasionally with a bad stop or parity bit.
        for (int n = 0; n < 10; n++) begin
            d      = 8'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 3) != 0);
            par_b  = (^d) ^ ($urandom_range(0, 3) == 0);
            snap();
            send_frame(d, stop_b, par_b);
            if (!stop_b) begin
                drive_bit(1'b0, 20);
                check_frame($sformatf("rnd%0d", n), d, stop_b, par_b);
                drive_bit(1'b1, 1);
                wait_idle($sformatf("rnd%0d", n), 10);
            end else begin
                check_frame($sformatf("rnd%0d", n), d, stop_b, par_b);
            end
            drive_bit(1'b1, $urandom_range(0, CPB));
        end

        chk("never_valid_and_ferr", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
